cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of result requesters (0=add, 1=mul, 2=bch).
REQ-002 Parameter DATA_W, 16, result data width.
REQ-003 Parameter TAG_W, 3, ROB index width.
REQ-004 Parameter CNT_W, 8, width of the performance counters.
REQ-005 clk1  in  1  sole clock; all state updates on posedge clk1.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NREQ  requester i has a completed result.
REQ-008 req_tag  in  NREQ*TAG_W  ROB index of requester i, slice i.
REQ-009 req_data  in  NREQ*DATA_W  result value of requester i, slice i.
REQ-010 req_ready  out  NREQ  combinational grant to requester i.
REQ-011 stall  in  1  ROB/regbank write port busy; no grant this cycle.
REQ-012 flush  in  1  pipeline flush; drops arbitration this cycle.
REQ-013 cdb_valid  out  1  registered broadcast strobe.
REQ-014 cdb_tag  out  TAG_W  broadcast ROB index.
REQ-015 cdb_data  out  DATA_W  broadcast value.
REQ-016 cdb_src  out  2  index of the granted requester.
REQ-017 conflict_cnt  out  CNT_W  cycles with two or more req_valid set, saturating.
REQ-018 grant_cnt  out  NREQ*CNT_W  per-requester grant count, saturating.

Function
REQ-019 At most one req_ready bit shall be high per cycle.
REQ-020 Transfer on requester i = req_valid[i] & req_ready[i].
REQ-021 req_ready[i] = 1 only if req_valid[i], !stall, !flush, and i is first valid in rotating order from rr_ptr.
REQ-022 Rotating order: rr_ptr, rr_ptr+1, ... modulo NREQ; index NREQ-1 wraps to 0.
REQ-023 After a transfer from i, rr_ptr shall become (i+1) mod NREQ on the next edge; otherwise it holds.
REQ-024 Latency: a transfer in cycle N shall give cdb_valid=1 with that tag, data and src = i in cycle N+1.
REQ-025 cdb_valid shall be a one-cycle pulse per transfer; no transfer means cdb_valid=0 next cycle.
REQ-026 cdb_tag/cdb_data/cdb_src shall hold last broadcast values while cdb_valid=0.
REQ-027 Requesters hold req_valid, tag and data stable until transfer; the arbiter shall not latch unaccepted requests.
REQ-028 stall=1: no grants, rr_ptr holds, cdb_valid=0 next cycle.
REQ-029 flush=1: no grants, rr_ptr resets to 0, cdb_valid=0 next cycle; flush wins over stall.
REQ-030 A flush arriving while cdb_valid=1 shall not retract the pulse already on the bus.
REQ-031 conflict_cnt increments when popcount(req_valid) >= 2, independent of stall/flush, saturating at all-ones.
REQ-032 grant_cnt slice i increments on each transfer from i, saturating at all-ones.
REQ-033 No req_valid set and no stall/flush: rr_ptr holds and outputs follow REQ-025/026.

Reset
REQ-034 On rst: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, all counters 0, req_ready=0.
REQ-035 rst asserted mid-transfer shall abort it; no broadcast after release for a pre-reset grant.
REQ-036 First grant after rst release follows priority add > mul > bch.

Structure
REQ-037 Shared package holds NREQ, DATA_W, TAG_W, CNT_W and source encodings SRC_ADD=0, SRC_MUL=1, SRC_BCH=2.
REQ-038 One sub-module rr_pick: combinational rotating-priority encoder (req vector, rr_ptr) -> one-hot grant and index.

Verification
REQ-039 All three valid, rr_ptr=0, tags 1/2/3, data 0x0011/0x0022/0x0033 held -> broadcasts tag1, tag2, tag3 on three consecutive cycles, src 0,1,2; conflict_cnt=2.
REQ-040 Only mul valid (tag 5, 0xBEEF) -> ready[1] same cycle; next cycle cdb_valid=1, tag 5, data 0xBEEF, src 1; rr_ptr=2.
REQ-041 Grant bch (rr_ptr wraps to 0), then add and bch valid -> add granted first, bch next.
REQ-042 stall high 2 cycles with add valid -> req_ready=0, cdb_valid=0 both cycles; grant in first cycle after stall drops.
REQ-043 flush with stall, mul and bch valid, rr_ptr=1 -> no grant, rr_ptr=0; next cycle mul granted (no add valid).
REQ-044 Drive add valid 300 cycles -> grant_cnt[0] saturates at 255; rst mid-transfer -> cdb_valid=0, all counters 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encodings for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SRC_W  = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_BCH = 2'd2
  } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-to-CDB bundle: result requests in, one broadcast and performance counters out.
interface cdb_arbiter_if #(
  parameter int unsigned NREQ   = cdb_arbiter_pkg::NREQ,
  parameter int unsigned DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int unsigned CNT_W  = cdb_arbiter_pkg::CNT_W
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   stall;
  logic                   flush;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;
  logic [CNT_W-1:0]       conflict_cnt;
  logic [NREQ*CNT_W-1:0]  grant_cnt;

  modport master (
    output req_valid, req_tag, req_data, stall, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt, grant_cnt
  );

  modport slave (
    input  req_valid, req_tag, req_data, stall, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt, grant_cnt
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr_i, wrapping past NREQ-1.
module cdb_arbiter_rr_pick #(
  parameter int unsigned  NREQ  = cdb_arbiter_pkg::NREQ,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_c,
  output logic [PTR_W-1:0] idx_c,
  output logic             any_c
);

  always_comb begin
    int unsigned pos;
    pos   = 0;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any_c && req_i[pos[PTR_W-1:0]]) begin
        any_c                   = 1'b1;
        idx_c                   = pos[PTR_W-1:0];
        gnt_c[pos[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one completed result per cycle onto a registered CDB broadcast.
module cdb_arbiter #(
  parameter int unsigned NREQ   = cdb_arbiter_pkg::NREQ,
  parameter int unsigned DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int unsigned CNT_W  = cdb_arbiter_pkg::CNT_W
) (
  input  logic         clk1,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  import cdb_arbiter_pkg::*;

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0]  grant_cnt_q [NREQ];
  logic [CNT_W-1:0]  grant_cnt_d [NREQ];

  logic [NREQ-1:0]   pick_gnt_c;
  logic [PTR_W-1:0]  pick_idx_c;
  logic              pick_any_c;
  logic              grant_ok_c;
  logic [NREQ-1:0]   ready_c;

  cdb_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Grant is suppressed by stall, flush and while reset is held.
  always_comb begin
    grant_ok_c = pick_any_c & ~bus.stall & ~bus.flush & ~rst;
    ready_c    = grant_ok_c ? pick_gnt_c : '0;
  end

  assign bus.req_ready = ready_c;

  always_comb begin
    int unsigned nvalid;
    nvalid         = 0;
    rr_ptr_d       = rr_ptr_q;
    cdb_valid_d    = grant_ok_c;
    cdb_tag_d      = cdb_tag_q;
    cdb_data_d     = cdb_data_q;
    cdb_src_d      = cdb_src_q;
    conflict_cnt_d = conflict_cnt_q;
    grant_cnt_d    = grant_cnt_q;

    for (int unsigned i = 0; i < NREQ; i++) nvalid += 32'(bus.req_valid[i]);
    if (nvalid >= 2 && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);

    if (bus.flush) begin
      rr_ptr_d = '0;
    end else if (grant_ok_c) begin
      rr_ptr_d = (pick_idx_c == PTR_W'(NREQ - 1)) ? '0 : pick_idx_c + PTR_W'(1);
    end

    if (grant_ok_c) begin
      cdb_tag_d  = bus.req_tag[pick_idx_c*TAG_W +: TAG_W];
      cdb_data_d = bus.req_data[pick_idx_c*DATA_W +: DATA_W];
      cdb_src_d  = SRC_W'(pick_idx_c);
      if (!(&grant_cnt_q[pick_idx_c]))
        grant_cnt_d[pick_idx_c] = grant_cnt_q[pick_idx_c] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= SRC_ADD;
      conflict_cnt_q <= '0;
      grant_cnt_q    <= '{default: '0};
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      cdb_src_q      <= cdb_src_d;
      conflict_cnt_q <= conflict_cnt_d;
      grant_cnt_q    <= grant_cnt_d;
    end
  end

  always_comb begin
    bus.cdb_valid    = cdb_valid_q;
    bus.cdb_tag      = cdb_tag_q;
    bus.cdb_data     = cdb_data_q;
    bus.cdb_src      = cdb_src_q;
    bus.conflict_cnt = conflict_cnt_q;
    bus.grant_cnt    = '0;
    for (int unsigned i = 0; i < NREQ; i++) bus.grant_cnt[i*CNT_W +: CNT_W] = grant_cnt_q[i];
  end

endmodule
